// File: rtl/exception_handler_unit.sv
// Exception entry/return sequencer between the ID-stage exception detector and the IF PC-select mux.
// Optional build macro EXCEP_HALT_ON_DOUBLE_EN adds a HALTED state entered on any double fault.
module exception_handler_unit #(
  parameter logic [31:0] HANDLER_VEC  = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               excep_flag,
  input  logic [31:0]        ID_PC,
  input  logic [6:0]         ID_opcode,
  input  logic               eret,
  output logic               flush_hold,
  output logic               pc_redirect,
  output logic [31:0]        redirect_target,
  output logic [31:0]        epc,
  output logic [6:0]         cause,
  output logic               in_handler,
  output logic [COUNT_W-1:0] excep_count,
  output logic               double_fault
);

  typedef enum logic [2:0] {
    IDLE, FLUSH, REDIRECT, HANDLER, RETURN
`ifdef EXCEP_HALT_ON_DOUBLE_EN
    , HALTED
`endif
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        epc_q, epc_d;
  logic [6:0]         cause_q, cause_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0]        target_q, target_d;
  logic               dfault_q, dfault_d;
  logic               flush_q, flush_d;
  logic               redir_q, redir_d;
  logic               inh_q, inh_d;
  logic               nested;

  assign nested = excep_flag && (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    count_d  = count_q;
    target_d = target_q;
    dfault_d = dfault_q | nested;
    case (state_q)
      IDLE: begin
        if (excep_flag) begin
          epc_d   = ID_PC;
          cause_d = ID_opcode;
          if (count_q != '1) count_d = count_q + COUNT_W'(1);
          cnt_d   = FLUSH_LOAD;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d  = REDIRECT;
          target_d = HANDLER_VEC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: state_d = HANDLER;
      HANDLER: begin
        if (eret) begin
          state_d  = RETURN;
          target_d = epc_q + 32'd4;
        end
      end
      RETURN: state_d = IDLE;
`ifdef EXCEP_HALT_ON_DOUBLE_EN
      HALTED: state_d = HALTED;
`endif
      default: state_d = IDLE;
    endcase
`ifdef EXCEP_HALT_ON_DOUBLE_EN
    // A double fault overrides every other transition, including a coincident eret.
    if (nested) begin
      state_d  = HALTED;
      target_d = target_q;
    end
`endif
  end

  always_comb begin
    flush_d = (state_d == FLUSH) || (state_d == REDIRECT);
`ifdef EXCEP_HALT_ON_DOUBLE_EN
    flush_d = flush_d || (state_d == HALTED);
`endif
    redir_d = (state_d == REDIRECT) || (state_d == RETURN);
    inh_d   = (state_d == HANDLER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      epc_q    <= 32'd0;
      cause_q  <= 7'd0;
      count_q  <= '0;
      target_q <= 32'd0;
      dfault_q <= 1'b0;
      flush_q  <= 1'b0;
      redir_q  <= 1'b0;
      inh_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
      target_q <= target_d;
      dfault_q <= dfault_d;
      flush_q  <= flush_d;
      redir_q  <= redir_d;
      inh_q    <= inh_d;
    end
  end

  assign flush_hold      = flush_q;
  assign pc_redirect     = redir_q;
  assign redirect_target = target_q;
  assign epc             = epc_q;
  assign cause           = cause_q;
  assign in_handler      = inh_q;
  assign excep_count     = count_q;
  assign double_fault    = dfault_q;

endmodule

// File: doc/exception_handler_unit.md
Name: exception_handler_unit

Overview:
- Sequential consumer of the ID-stage exception flag and the ID PC/opcode.
- On an illegal-opcode exception it captures EPC and cause, holds the pipeline flush for a programmable number of cycles, then redirects fetch to the handler vector.
- Returns to EPC+4 on eret.
- Sits between the exception detector and the PC-select mux in IF.

Parameters:
- HANDLER_VEC, 32'h0000_0100, fetch address of the exception handler.
- FLUSH_CYCLES, 2, number of cycles flush_hold stays high before redirect (legal range 1..15).
- COUNT_W, 8, width of the exception event counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- excep_flag  input  1  exception request from the ID-stage detector.
- ID_PC  input  32  PC of the instruction in ID.
- ID_opcode  input  7  opcode of the instruction in ID.
- eret  input  1  return-from-handler strobe from the decoder.
- flush_hold  output  1  keeps IF/ID/EX/MEM flushed while the exception is being entered.
- pc_redirect  output  1  one-cycle pulse; IF loads redirect_target.
- redirect_target  output  32  PC to load when pc_redirect=1.
- epc  output  32  captured PC of the faulting instruction.
- cause  output  7  captured faulting opcode.
- in_handler  output  1  high while handler code executes.
- excep_count  output  COUNT_W  number of accepted exceptions, saturating.
- double_fault  output  1  sticky; an exception arrived while not IDLE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - flush_hold, pc_redirect, in_handler, double_fault are 0.
  - epc, cause, excep_count, redirect_target are 0.
- Reset deasserted mid-operation: the next state is always IDLE and no pending redirect survives.
- FSM states: IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
- IDLE:
  - excep_flag=1 at a rising edge: epc<=ID_PC, cause<=ID_opcode, excep_count increments (saturates at all-ones), flush counter loads FLUSH_CYCLES-1, go to FLUSH.
  - eret in IDLE is ignored.
- FLUSH:
  - flush_hold=1.
  - Counter decrements each cycle; on counter==0 go to REDIRECT.
  - Total FLUSH residence is FLUSH_CYCLES cycles.
- REDIRECT, exactly one cycle:
  - pc_redirect=1, redirect_target=HANDLER_VEC, flush_hold=1.
  - Go to HANDLER.
- HANDLER:
  - in_handler=1, flush_hold=0.
  - eret=1 goes to RETURN.
- RETURN, exactly one cycle:
  - pc_redirect=1, redirect_target=epc+4 (32-bit modulo add, so 32'hFFFF_FFFC wraps to 0).
  - in_handler=0; go to IDLE.
- Latency from the excep_flag edge:
  - flush_hold is high from the next cycle.
  - pc_redirect pulses FLUSH_CYCLES+1 cycles after the accepting edge.
- Nested exceptions:
  - excep_flag=1 in any state other than IDLE sets double_fault (sticky until reset).
  - epc, cause and excep_count are not modified.
  - The state transition proceeds as if excep_flag were 0, unless the optional feature is enabled.
- Simultaneous events:
  - excep_flag and eret both high in HANDLER: eret wins (go to RETURN) and double_fault is set.
  - excep_flag in the RETURN cycle: double_fault is set, the return completes, and the flag is not accepted. The detector re-asserts it in a later cycle if the condition persists.
- Output timing: outputs are registered or decoded from registered state only; there is no combinational path from excep_flag to pc_redirect.
- redirect_target holds its last value when pc_redirect=0.

Optional Feature:
- Macro: EXCEP_HALT_ON_DOUBLE_EN.
- Defined:
  - Adds state HALTED. Any double fault (excep_flag=1 while not IDLE) moves to HALTED at that edge.
  - In HALTED: flush_hold=1, in_handler=0, pc_redirect=0, eret ignored. Exit only through rst.
  - The eret+excep_flag tie in HANDLER goes to HALTED.
- Not defined: no HALTED state; double faults only set the sticky double_fault flag, as described above.

Test Plan:
- Reset check: rst=1 with clk running, then release -> all outputs 0 and excep_flag=0 keeps the block in IDLE for 10 cycles.
- Basic entry, FLUSH_CYCLES=2: excep_flag=1 for 1 cycle with ID_PC=32'h40, ID_opcode=7'h7F -> epc=32'h40, cause=7'h7F, flush_hold high 3 cycles, pc_redirect pulse on the 3rd with target 32'h100, then in_handler=1, excep_count=1.
- Return: in HANDLER assert eret 1 cycle -> next cycle pc_redirect=1, target=32'h44, then IDLE with in_handler=0.
- Wrap: capture ID_PC=32'hFFFF_FFFC, eret -> redirect_target=32'h0000_0000.
- Double fault: excep_flag during HANDLER with ID_PC=32'h80 -> double_fault=1, epc stays 32'h40, excep_count unchanged.
  - With EXCEP_HALT_ON_DOUBLE_EN: HALTED, flush_hold=1, eret ignored until rst.
- Async reset mid-FLUSH: rst pulse between clock edges -> outputs clear immediately (before the next edge), no pc_redirect issued afterward; excep_count saturates at 8'hFF after 300 exceptions.
